// File: rtl/joy_hotkey.sv
// joy_hotkey: watches CPU joypad reads, reassembles the two nibbles into a
// pad byte and fires a one-clock event when a configured key combination
// has been seen on HOLD_SMP consecutive pad samples. After firing, the
// tracker waits for an all-released sample before it re-arms.
// cfg packing: cfg[23:16] = key_menu, cfg[15:8] = key_save, cfg[7:0] = key_load.
module joy_hotkey #(
   parameter int unsigned HOLD_SMP  = 30,
   parameter int unsigned STALE_CYC = 2_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] cfg,
   input  logic        pad_stb,
   input  logic        pad_sel,
   input  logic [3:0]  pad_dat,
   output logic        evt_menu,
   output logic        evt_save,
   output logic        evt_load,
   output logic        busy
);

   localparam int unsigned CW = $clog2(HOLD_SMP + 1);
   localparam int unsigned TW = $clog2(STALE_CYC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_WAIT_REL} state_t;
   typedef enum logic [1:0] {KEY_MENU, KEY_SAVE, KEY_LOAD, KEY_NONE} key_t;

   logic [7:0]    key_menu, key_save, key_load;
   logic [3:0]    dpad;
   logic          half;
   logic [7:0]    sample;
   logic          smp_v;
   logic [TW-1:0] tmr;
   logic          stale_hit, stale_kill;
   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   key_t          trk_id;
   logic [7:0]    trk_q;
   key_t          sel_id;
   logic [7:0]    sel_code;
   logic          sel_hit;
   logic [7:0]    trk_code;
   logic          trk_match, cfg_chg, last_smp;
   key_t          fire_id;
   logic          evt_menu_nxt, evt_save_nxt, evt_load_nxt;

   assign key_menu = cfg[23:16];
   assign key_save = cfg[15:8];
   assign key_load = cfg[7:0];

   // Nibble capture and pad byte assembly; smp_v pulses the clock after a pair completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dpad   <= '0;
         half   <= 1'b0;
         sample <= '0;
         smp_v  <= 1'b0;
      end else begin
         smp_v <= 1'b0;
         if (stale_kill) half <= 1'b0;
         if (pad_stb) begin
            if (pad_sel) begin
               dpad <= ~pad_dat;
               half <= 1'b1;
            end else if (half) begin
               sample <= {dpad, ~pad_dat};
               half   <= 1'b0;
               smp_v  <= 1'b1;
            end
         end
      end
   end

   // Stale timer: clocks since the last sample, saturating at STALE_CYC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       tmr <= '0;
      else if (smp_v)                   tmr <= '0;
      else if (tmr != TW'(STALE_CYC))   tmr <= tmr + TW'(1);
   end

   // A sample arriving in the expiry cycle takes precedence over the timeout
   assign stale_hit  = !smp_v && (tmr == TW'(STALE_CYC));
   assign stale_kill = stale_hit && (state != ST_IDLE);

   // Key match with fixed priority menu > save > load; a zero code never matches
   always_comb begin
      sel_id   = KEY_NONE;
      sel_code = '0;
      if (key_menu != '0 && key_menu == sample) begin
         sel_id   = KEY_MENU;
         sel_code = key_menu;
      end else if (key_save != '0 && key_save == sample) begin
         sel_id   = KEY_SAVE;
         sel_code = key_save;
      end else if (key_load != '0 && key_load == sample) begin
         sel_id   = KEY_LOAD;
         sel_code = key_load;
      end
   end

   assign sel_hit = (sel_id != KEY_NONE);

   // Current configured code of the key being tracked
   always_comb begin
      case (trk_id)
         KEY_MENU: trk_code = key_menu;
         KEY_SAVE: trk_code = key_save;
         KEY_LOAD: trk_code = key_load;
         default:  trk_code = '0;
      endcase
   end

   // trk_q snapshots the code at HOLD entry so a cfg rewrite can be detected
   assign trk_match = (trk_code != '0) && (trk_code == sample);
   assign cfg_chg   = (trk_code != trk_q);
   assign last_smp  = (cnt == CW'(HOLD_SMP - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (smp_v && sel_hit)
               state_nxt = (HOLD_SMP == 1) ? ST_WAIT_REL : ST_HOLD;
         end
         ST_HOLD: begin
            if (stale_kill || cfg_chg)
               state_nxt = ST_IDLE;
            else if (smp_v)
               state_nxt = !trk_match ? ST_IDLE : (last_smp ? ST_WAIT_REL : ST_HOLD);
         end
         ST_WAIT_REL: begin
            if (stale_kill || (smp_v && sample == '0))
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Hold counter and tracked-key bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         trk_id <= KEY_NONE;
         trk_q  <= '0;
      end else if (state_nxt == ST_IDLE) begin
         cnt <= '0;
      end else if (state == ST_IDLE) begin
         cnt    <= CW'(1);
         trk_id <= sel_id;
         trk_q  <= sel_code;
      end else if (state == ST_HOLD && smp_v && trk_match && cnt != CW'(HOLD_SMP)) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Output decode: which key fires this cycle, and busy from state
   always_comb begin
      fire_id = KEY_NONE;
      case (state)
         ST_IDLE: if (smp_v && sel_hit && HOLD_SMP == 1) fire_id = sel_id;
         ST_HOLD: if (!cfg_chg && smp_v && trk_match && last_smp) fire_id = trk_id;
         default: fire_id = KEY_NONE;
      endcase
      evt_menu_nxt = (fire_id == KEY_MENU);
      evt_save_nxt = (fire_id == KEY_SAVE);
      evt_load_nxt = (fire_id == KEY_LOAD);
      busy         = (state != ST_IDLE);
   end

   // Registered event pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_menu <= 1'b0;
         evt_save <= 1'b0;
         evt_load <= 1'b0;
      end else begin
         evt_menu <= evt_menu_nxt;
         evt_save <= evt_save_nxt;
         evt_load <= evt_load_nxt;
      end
   end

endmodule

// File: tb/tb_joy_hotkey.sv
// Testbench for joy_hotkey: two instances (HOLD_SMP=3 and HOLD_SMP=1) share
// stimulus; a transaction-level model predicts busy and event counts.
module tb_joy_hotkey;

   localparam int unsigned HS = 3;
   localparam int unsigned SC = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] cfg = '0;
   logic        pad_stb = 1'b0;
   logic        pad_sel = 1'b0;
   logic [3:0]  pad_dat = '1;
   logic [2:0]  ev0, ev1;
   logic        busy0, busy1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   joy_hotkey #(.HOLD_SMP(HS), .STALE_CYC(SC)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg(cfg), .pad_stb(pad_stb), .pad_sel(pad_sel),
      .pad_dat(pad_dat), .evt_menu(ev0[0]), .evt_save(ev0[1]), .evt_load(ev0[2]),
      .busy(busy0));

   joy_hotkey #(.HOLD_SMP(1), .STALE_CYC(SC)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cfg(cfg), .pad_stb(pad_stb), .pad_sel(pad_sel),
      .pad_dat(pad_dat), .evt_menu(ev1[0]), .evt_save(ev1[1]), .evt_load(ev1[2]),
      .busy(busy1));

   // Observed pulse counters and multi-hot detector
   int pc [2][3];
   int hot_err = 0;
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (ev0[k] === 1'b1) pc[0][k]++;
         if (ev1[k] === 1'b1) pc[1][k]++;
      end
      if ($countones(ev0) > 1 || $countones(ev1) > 1) hot_err++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] keys [3];
   int         hold_n [2];
   int         trk [2];
   int         cnt [2];
   int         wr [2];
   logic [7:0] snap [2];
   int         epc [2][3];

   function automatic int prio(input logic [7:0] s);
      for (int k = 0; k < 3; k++)
         if (keys[k] != 8'h00 && keys[k] == s) return k;
      return -1;
   endfunction

   function automatic void model_sample(input logic [7:0] s);
      for (int i = 0; i < 2; i++) begin
         if (wr[i] != 0) begin
            if (s == 8'h00) wr[i] = 0;
         end else if (trk[i] < 0) begin
            int id;
            id = prio(s);
            if (id >= 0) begin
               if (hold_n[i] == 1) begin
                  wr[i] = 1;
                  epc[i][id]++;
               end else begin
                  trk[i] = id; cnt[i] = 1; snap[i] = keys[id];
               end
            end
         end else if (keys[trk[i]] != 8'h00 && keys[trk[i]] == s) begin
            cnt[i]++;
            if (cnt[i] >= hold_n[i]) begin
               epc[i][trk[i]]++;
               trk[i] = -1; wr[i] = 1;
            end
         end else begin
            trk[i] = -1;
         end
      end
   endfunction

   function automatic void model_cfg();
      for (int i = 0; i < 2; i++)
         if (trk[i] >= 0 && keys[trk[i]] != snap[i]) trk[i] = -1;
   endfunction

   function automatic void model_idle();
      for (int i = 0; i < 2; i++) begin
         trk[i] = -1; wr[i] = 0; cnt[i] = 0;
      end
   endfunction

   task automatic check_all(input string tag);
      chk($sformatf("%s busy0", tag), {31'd0, busy0}, {31'd0, (trk[0] >= 0 || wr[0] != 0)});
      chk($sformatf("%s busy1", tag), {31'd0, busy1}, {31'd0, (trk[1] >= 0 || wr[1] != 0)});
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 3; k++)
            chk($sformatf("%s pulses i%0d k%0d", tag, i, k), pc[i][k], epc[i][k]);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic strobe(input logic sel, input logic [3:0] raw);
      @(negedge clk);
      pad_stb = 1'b1; pad_sel = sel; pad_dat = raw;
      @(negedge clk);
      pad_stb = 1'b0;
   endtask

   task automatic settle_check(input string tag);
      @(negedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic send_sample(input logic [7:0] s, input string tag);
      strobe(1'b1, ~s[7:4]);
      strobe(1'b0, ~s[3:0]);
      model_sample(s);
      settle_check(tag);
   endtask

   task automatic set_keys(input logic [7:0] m, input logic [7:0] sv, input logic [7:0] l);
      keys[0] = m; keys[1] = sv; keys[2] = l;
      @(negedge clk);
      cfg = {m, sv, l};
      model_cfg();
      settle_check("cfg");
   endtask

   function automatic logic [7:0] pick_code();
      case ($urandom_range(0, 5))
         0: return 8'h00;
         1: return 8'h0C;
         2: return 8'h81;
         3: return 8'h30;
         4: return 8'h83;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   int base;
   logic [7:0] s;

   initial begin
      hold_n[0] = HS; hold_n[1] = 1;
      for (int k = 0; k < 3; k++) keys[k] = 8'h00;
      model_idle();
      for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) epc[i][k] = 0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("reset ev0", {29'd0, ev0}, 32'd0);
      chk("reset ev1", {29'd0, ev1}, 32'd0);
      chk("reset busy0", {31'd0, busy0}, 32'd0);
      chk("reset busy1", {31'd0, busy1}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fire: Run+Select held three samples
      set_keys(8'h0C, 8'h81, 8'h00);
      base = pc[0][0];
      send_sample(8'h0C, "fire1");
      send_sample(8'h0C, "fire2");
      chk("fire before third", pc[0][0] - base, 0);
      send_sample(8'h0C, "fire3");
      chk("fire after third", pc[0][0] - base, 1);
      send_sample(8'h0C, "waitrel");
      chk("waitrel busy", {31'd0, busy0}, 32'd1);
      send_sample(8'h00, "release");
      chk("release busy", {31'd0, busy0}, 32'd0);

      // Break: 0x83 interrupts the run
      base = pc[0][1];
      send_sample(8'h81, "brk1");
      send_sample(8'h81, "brk2");
      send_sample(8'h83, "brk3");
      send_sample(8'h81, "brk4");
      send_sample(8'h81, "brk5");
      chk("break no early fire", pc[0][1] - base, 0);
      send_sample(8'h81, "brk6");
      chk("break fire sixth", pc[0][1] - base, 1);
      send_sample(8'h00, "brk rel");

      // Priority and disabled key
      set_keys(8'h30, 8'h00, 8'h30);
      repeat (3) send_sample(8'h00, "zero");
      repeat (3) send_sample(8'h30, "prio");
      chk("prio load none", pc[0][2] + pc[1][2], 0);
      send_sample(8'h00, "prio rel");

      // Nibble pairing: lone button nibble ignored, second d-pad nibble wins
      set_keys(8'h81, 8'h00, 8'h00);
      base = pc[0][0];
      for (int r = 0; r < 3; r++) begin
         strobe(1'b0, 4'hE);
         settle_check("lone");
         strobe(1'b1, 4'hE);
         strobe(1'b1, 4'h7);
         strobe(1'b0, 4'hE);
         model_sample(8'h81);
         settle_check("pair");
      end
      chk("pairing fire", pc[0][0] - base, 1);
      send_sample(8'h00, "pair rel");

      // Stale: no strobes while holding
      set_keys(8'h0C, 8'h81, 8'h00);
      send_sample(8'h0C, "stale enter");
      repeat (SC - 1) @(negedge clk);
      #1;
      check_all("stale before");
      repeat (4) @(negedge clk);
      #1;
      model_idle();
      check_all("stale after");
      send_sample(8'h0C, "stale restart1");
      send_sample(8'h0C, "stale restart2");
      send_sample(8'h0C, "stale restart3");
      send_sample(8'h00, "stale rel");

      // Config change while holding
      send_sample(8'h81, "cfgchg hold");
      set_keys(8'h0C, 8'h83, 8'h00);
      chk("cfgchg busy0", {31'd0, busy0}, 32'd0);
      send_sample(8'h00, "cfgchg rel");

      // Reset mid-HOLD with cnt = HS-1
      send_sample(8'h0C, "rst h1");
      send_sample(8'h0C, "rst h2");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst ev0", {29'd0, ev0}, 32'd0);
      chk("rst busy0", {31'd0, busy0}, 32'd0);
      chk("rst busy1", {31'd0, busy1}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_idle();
      base = pc[0][0];
      send_sample(8'h0C, "rst after1");
      chk("rst no pulse", pc[0][0] - base, 0);
      send_sample(8'h00, "rst rel");

      // Randomized phase
      for (int n = 0; n < 400; n++) begin
         int op;
         op = $urandom_range(0, 99);
         if (op < 5) begin
            set_keys(pick_code(), pick_code(), pick_code());
         end else if (op < 10) begin
            strobe(1'b0, 4'($urandom));
            settle_check("rnd lone");
         end else begin
            if (op < 60) s = keys[$urandom_range(0, 2)];
            else if (op < 75) s = 8'h00;
            else s = pick_code();
            if (op >= 90) strobe(1'b1, 4'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_sample(s, "rnd");
         end
      end

      chk("onehot", hot_err, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/joy_hotkey.md
JOY_HOTKEY -- requirements
Module: joy_hotkey

Interface
REQ-001 SHALL have parameter HOLD_SMP, default 30, giving the number of consecutive matching pad samples required to fire a hotkey.
REQ-002 SHALL have parameter STALE_CYC, default 2_000_000, giving the clocks without a pad sample before the tracker is abandoned.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg  in  SysCfg  configuration; uses key_menu, key_save and key_load (8 bits each).
- pad_stb  in  1  one-cycle strobe: the CPU read a joypad nibble.
- pad_sel  in  1  SEL line level at that read; 1 means d-pad nibble, 0 means button nibble.
- pad_dat  in  4  raw nibble at that read, active-low.
- evt_menu  out  1  one-cycle hotkey pulse.
- evt_save  out  1  one-cycle hotkey pulse.
- evt_load  out  1  one-cycle hotkey pulse.
- busy  out  1  high in HOLD or WAIT_REL.

Function
REQ-005 Nibble capture: pad_stb with pad_sel=1 SHALL latch ~pad_dat into dpad[3:0] and set the half flag.
REQ-006 Pad byte assembly: pad_stb with pad_sel=0 while half=1 SHALL form sample = {dpad, ~pad_dat}, clear half, and raise an internal one-cycle smp_v on the next clock.
- Bit order [7:0] = left, down, right, up, run, select, II, I.
REQ-007 pad_stb with pad_sel=0 while half=0 SHALL be ignored; no sample is formed.
REQ-008 A second pad_sel=1 strobe before a button nibble SHALL overwrite dpad; half stays 1.
REQ-009 Match: a key code matches when it is non-zero and equals the sample exactly; code 0x00 SHALL never match.
REQ-010 Priority: if several codes match, SHALL select menu > save > load; only the selected one is tracked.
REQ-011 FSM states: IDLE, HOLD, WAIT_REL.
REQ-012 IDLE: on smp_v with a match, SHALL go to HOLD, record the selected key id, and set cnt=1.
REQ-013 HOLD, smp_v with the same id matching: SHALL increment cnt (saturating, width ceil(log2(HOLD_SMP+1))).
- When cnt reaches HOLD_SMP, SHALL pulse the corresponding evt_* for exactly one clock, in the cycle after that smp_v.
- Then SHALL go to WAIT_REL.
REQ-014 HOLD, smp_v with any other sample: SHALL return to IDLE with cnt=0; the new sample is not re-evaluated in the same cycle.
REQ-015 WAIT_REL: SHALL stay until a sample equal to 0x00 arrives, then go to IDLE; no evt_* fires in WAIT_REL.
REQ-016 HOLD_SMP=1: SHALL fire on the first matching sample.
- Path IDLE -> WAIT_REL; evt_* one clock after smp_v.
REQ-017 Config change: any change of the tracked key code while in HOLD SHALL force IDLE with cnt=0 on the next clock; changes in IDLE or WAIT_REL have no effect.
REQ-018 Stale timer: SHALL count clocks since the last smp_v and reset to 0 on each smp_v.
- On reaching STALE_CYC in HOLD or WAIT_REL: SHALL force IDLE, clear half, and saturate the timer.
REQ-019 Simultaneous stale expiry and smp_v in the same cycle: smp_v SHALL win and the timer resets.
REQ-020 At most one evt_* SHALL be high in any cycle; evt_* SHALL be registered outputs.
REQ-021 busy SHALL be high exactly in HOLD and WAIT_REL.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE, cnt=0, half=0, dpad=0, stale timer=0, evt_menu=evt_save=evt_load=0, busy=0.
REQ-023 Deassertion mid-HOLD SHALL restart matching from IDLE; no pulse SHALL be emitted on reset entry or exit.

Verification
REQ-024 Fire: key_menu=0x0C (Run+Select), HOLD_SMP=3, three sample pairs each equal to 0x0C -> exactly one evt_menu pulse one clock after the third smp_v; busy=1 until a 0x00 sample arrives.
REQ-025 Break: key_save=0x81, samples 0x81, 0x81, 0x83, 0x81, 0x81, 0x81 with HOLD_SMP=3 -> evt_save fires only after the sixth sample.
REQ-026 Priority and disable: key_menu=key_load=0x30, key_save=0x00, sample 0x00 repeated -> no events; then samples of 0x30 -> only evt_menu.
REQ-027 Nibble pairing: button nibble with no preceding d-pad nibble -> no smp_v; two d-pad nibbles (0xE then 0x7) followed by a button nibble -> dpad=0x8 is used.
REQ-028 Stale: enter HOLD, then give no strobes for STALE_CYC clocks -> IDLE and busy=0; further matching samples restart cnt at 1.
REQ-029 Reset in HOLD: assert rst_n=0 for one cycle with cnt=HOLD_SMP-1 -> all outputs 0 immediately; the next matching sample gives cnt=1 and no pulse.
